// File: rtl/rv32_pipe_pkg.sv
// Shared constants for the RV32 pipeline stage registers.
// Payload widths per stage pair and the canonical NOP used as a cleared payload.
package rv32_pipe_pkg;

    // PC + PC4 + inst + rs1/rs2/rd
    localparam int IFID_W  = 111;
    localparam int IDEX_W  = 32 + 32 + 32 + 32 + 15 + 16;
    localparam int EXMEM_W = 32 + 32 + 32 + 5 + 8;
    localparam int MEMWB_W = 32 + 32 + 5 + 4;

    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

    function automatic logic [1:0] count_valid(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready skid stage (main + skid) with registered in_ready,
// synchronous flush and a saturating stall-cycle counter.
module pipe_skid_stage
    import rv32_pipe_pkg::*;
#(
    parameter int                DATA_W   = IFID_W,
    parameter bit                CLR_DATA = 1'b1,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clr
);

    logic              r_main_valid;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;

    logic w_acc;
    logic w_pop;
    logic w_stall;

    // in_ready is the complement of a flop, so no combinational path from out_ready.
    assign in_ready = ~r_skid_valid;
    assign w_acc    = in_valid & in_ready;
    assign w_pop    = r_main_valid & out_ready;
    assign w_stall  = r_main_valid & ~out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= CLR_VAL;
            r_skid_data  <= CLR_VAL;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            if (CLR_DATA) begin
                r_main_data <= CLR_VAL;
                r_skid_data <= CLR_VAL;
            end
        end else if (!r_main_valid || w_pop) begin
            // Main is free this edge: the skid entry drains first to keep FIFO order.
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_acc) begin
                r_main_data  <= in_data;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_acc) begin
            r_skid_data  <= in_data;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign occupancy = count_valid(r_main_valid, r_skid_valid);

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_stall),
        .i_clr (cnt_clr),
        .o_cnt (stall_cnt)
    );

endmodule
